decode_stage_v2: RTL and testbench
==================================

DECODE_STAGE_V2 -- requirements
Module: decode_stage_v2

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register-file and operand width (instruction and PC are always 32).
REQ-002 Parameter REG_ADDR_W, default 5, SHALL set the register address width; register count is 2**REG_ADDR_W.
REQ-003 Parameter CNT_W, default 16, SHALL set the bubble-counter width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 if_id_valid  input  1  the IF/ID slot holds a real instruction.
REQ-007 if_id_instr, if_id_pc_plus4  input  32 each  instruction and its PC+4.
REQ-008 stall_en  input  1  load-use stall request from the hazard unit.
REQ-009 ex_hold  input  1  downstream back-pressure; ID/EX must keep its contents.
REQ-010 wb_reg_write / wb_wr_addr / wb_wr_data  input  1 / REG_ADDR_W / DATA_W  write-back port.
REQ-011 id_rs, id_rt  output  REG_ADDR_W each  combinational source fields, sent to the hazard unit.
REQ-012 redirect_valid / redirect_pc / if_id_flush  output  1 / 32 / 1  front-end redirect and IF/ID squash.
REQ-013 id_ex_valid, id_ex_ctrl[7:0], id_ex_rd_data1, id_ex_rd_data2, id_ex_imm, id_ex_rs, id_ex_rt, id_ex_rd  output  registered ID/EX contents.
REQ-014 bubble_cnt  output  CNT_W  number of bubbles inserted.

Function
REQ-015 Decoding SHALL support R-type (0x00), lw (0x23), sw (0x2B), addi (0x08), beq (0x04), bne (0x05) and j (0x02); any other opcode SHALL decode to all-zero control.
REQ-016 id_ex_ctrl SHALL be {RegDst, ALUSrc, ALUOp[1:0], MemWrite, MemRead, MemToReg, RegWrite}.
REQ-017 Register reads SHALL be combinational; register 0 SHALL always read 0 and SHALL ignore writes.
REQ-018 A write-back to the same non-zero register in the same cycle SHALL bypass: the read returns wb_wr_data.
REQ-019 A branch SHALL be taken when if_id_valid is 1, stall_en is 0, and either (beq and operand1 == operand2) or (bne and operand1 != operand2), compared after the bypass.
REQ-020 The branch target SHALL be if_id_pc_plus4 + (sign-extended imm16 << 2), computed modulo 2**32.
REQ-021 The jump target SHALL be {if_id_pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-022 redirect_valid and if_id_flush SHALL both be combinational and equal to (taken branch OR valid unstalled jump).
REQ-023 redirect_pc SHALL be the jump target if the instruction is j, else the branch target.
REQ-024 Redirect SHALL be suppressed while stall_en=1 or ex_hold=1.
REQ-025 Immediates SHALL be sign-extended to DATA_W.
REQ-026 ID/EX update priority: ex_hold=1 SHALL hold all fields.
REQ-027 Otherwise, stall_en=1 SHALL load a bubble: valid=0, ctrl=0, other fields don't-care.
REQ-028 Otherwise, the register SHALL load the decoded instruction with id_ex_valid = if_id_valid.
REQ-029 Branches and jumps SHALL enter ID/EX with ctrl=0 and valid=1.
REQ-030 Latency from IF/ID to ID/EX SHALL be one cycle.
REQ-031 bubble_cnt SHALL increment on each cycle where stall_en=1 and ex_hold=0, and SHALL saturate at all-ones.
REQ-032 When ex_hold=1 and stall_en=1 occur together, the hold SHALL win and bubble_cnt SHALL NOT increment.

Reset
REQ-033 While rst=0, all ID/EX fields, id_ex_valid and bubble_cnt SHALL be 0, and all registers SHALL be 0, asynchronously.
REQ-034 A reset asserted mid-stall SHALL discard the bubble and hold state.
REQ-035 On the first edge after release, the block SHALL load normally.

Structure
REQ-036 Opcode constants, the ALUOp encoding and the ctrl bit positions SHALL live in a shared package used by the execute stage.
REQ-037 The register file SHALL be a separate sub-module, regfile_bypass, parameterised by DATA_W and REG_ADDR_W.

Verification
REQ-038 Reset with rst=0 for 3 cycles, then release -> all outputs 0 and bubble_cnt=0.
REQ-039 Load r3=5, r4=5, then beq r3,r4,+4 at pc_plus4=0x100 -> redirect_valid=1, redirect_pc=0x110, if_id_flush=1.
REQ-040 Same setup as REQ-039 with bne -> redirect_valid=0.
REQ-041 WB writes r7=0xA5 in the same cycle as addi r8,r7 is decoded -> next cycle id_ex_rd_data1=0xA5.
REQ-042 stall_en=1 for 2 cycles -> two bubbles (valid=0, ctrl=0), bubble_cnt=2; repeat with ex_hold=1 -> ID/EX unchanged, bubble_cnt unchanged.
REQ-043 CNT_W=2 with 5 stalls -> bubble_cnt=3; j 0x0000040 at pc_plus4=0x30000004 -> redirect_pc=0x30000100.

Source files
------------

// File: rtl/decode_stage_v2_pkg.sv
// Shared decode definitions for the ID and EX stages.
// Holds the opcode constants, the ALUOp encoding, the bit positions of the
// 8-bit control word and a helper that maps an opcode to its control word.
// Any stage that consumes id_ex_ctrl should import this package rather than
// repeat the encodings.
package decode_stage_v2_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    // ALU_SUB is reserved for the execute stage; branches resolve in ID and
    // therefore never send it down the pipe.
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    // Bit positions inside id_ex_ctrl.
    localparam int CTRL_REG_DST    = 7;
    localparam int CTRL_ALU_SRC    = 6;
    localparam int CTRL_ALU_OP_HI  = 5;
    localparam int CTRL_ALU_OP_LO  = 4;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_REG_WRITE  = 0;

    // Member order matches the bit positions above (first member is bit 7).
    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        alu_op_e alu_op;
        logic    mem_write;
        logic    mem_read;
        logic    mem_to_reg;
        logic    reg_write;
    } ctrl_t;

    // Branches, jumps and unknown opcodes produce an all-zero control word.
    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.alu_op    = ALU_FUNCT;
                c.reg_write = 1'b1;
            end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.alu_op     = ALU_ADD;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_ADD;
                c.mem_write = 1'b1;
            end
            OP_ADDI: begin
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_ADD;
                c.reg_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_v2_regfile_bypass.sv
// Register file with two combinational read ports and one write port.
// Register 0 reads as zero and ignores writes. A read of the register being
// written in the same cycle returns the incoming write data.
// Ports:
//   clk, rst              clock, asynchronous active-low reset (clears all registers)
//   we, wr_addr, wr_data  write port
//   rd_addr1/2            read addresses
//   rd_data1/2            read data (bypassed)
module regfile_bypass #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr1,
    input  logic [REG_ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0]     rd_data1,
    output logic [DATA_W-1:0]     rd_data2
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_live;

    assign wr_live = we && (wr_addr != '0);

    // NOTE: this array is reset element by element because the pipeline must
    // see all-zero registers after reset; that forces flops rather than RAM.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // NOTE: each output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_data2 = regs[rd_addr2];
        if (rd_addr1 == '0)                          rd_data1 = '0;
        else if (wr_live && (wr_addr == rd_addr1))   rd_data1 = wr_data;
        if (rd_addr2 == '0)                          rd_data2 = '0;
        else if (wr_live && (wr_addr == rd_addr2))   rd_data2 = wr_data;
    end

endmodule

// File: rtl/decode_stage_v2.sv
// Instruction decode stage: register read with write-back bypass, branch and
// jump resolution with front-end redirect, and the ID/EX pipeline register.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   if_id_valid/instr/pc_plus4    IF/ID slot contents
//   stall_en                      load-use stall (inserts a bubble)
//   ex_hold                       downstream back-pressure (ID/EX holds)
//   wb_reg_write/wr_addr/wr_data  write-back port into the register file
//   id_rs, id_rt                  source fields for the hazard unit
//   redirect_valid/pc, if_id_flush  redirect for taken branches and jumps
//   id_ex_*                       registered ID/EX contents
//   bubble_cnt                    saturating count of bubbles inserted
module decode_stage_v2
    import decode_stage_v2_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_id_valid,
    input  logic [31:0]           if_id_instr,
    input  logic [31:0]           if_id_pc_plus4,
    input  logic                  stall_en,
    input  logic                  ex_hold,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_wr_addr,
    input  logic [DATA_W-1:0]     wb_wr_data,
    output logic [REG_ADDR_W-1:0] id_rs,
    output logic [REG_ADDR_W-1:0] id_rt,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    output logic                  if_id_flush,
    output logic                  id_ex_valid,
    output logic [7:0]            id_ex_ctrl,
    output logic [DATA_W-1:0]     id_ex_rd_data1,
    output logic [DATA_W-1:0]     id_ex_rd_data2,
    output logic [DATA_W-1:0]     id_ex_imm,
    output logic [REG_ADDR_W-1:0] id_ex_rs,
    output logic [REG_ADDR_W-1:0] id_ex_rt,
    output logic [REG_ADDR_W-1:0] id_ex_rd,
    output logic [CNT_W-1:0]      bubble_cnt
);

    logic [5:0]            opcode;
    logic [15:0]           imm16;
    logic [REG_ADDR_W-1:0] rd_field;
    logic [DATA_W-1:0]     rd_data1, rd_data2, imm_ext;
    logic [31:0]           branch_target, jump_target;
    logic                  front_ok, branch_taken, jump_taken;
    ctrl_t                 ctrl;

    assign opcode   = if_id_instr[31:26];
    assign imm16    = if_id_instr[15:0];
    assign id_rs    = REG_ADDR_W'(if_id_instr[25:21]);
    assign id_rt    = REG_ADDR_W'(if_id_instr[20:16]);
    assign rd_field = REG_ADDR_W'(if_id_instr[15:11]);
    assign imm_ext  = DATA_W'($signed(imm16));
    assign ctrl     = decode_ctrl(opcode);

    regfile_bypass #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_reg_write),
        .wr_addr  (wb_wr_addr),
        .wr_data  (wb_wr_data),
        .rd_addr1 (id_rs),
        .rd_addr2 (id_rt),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2)
    );

    // A redirect is only meaningful when this instruction actually advances;
    // a stalled or held slot will be presented again later.
    assign front_ok      = if_id_valid && !stall_en && !ex_hold;
    assign branch_taken  = front_ok &&
                           (((opcode == OP_BEQ) && (rd_data1 == rd_data2)) ||
                            ((opcode == OP_BNE) && (rd_data1 != rd_data2)));
    assign jump_taken    = front_ok && (opcode == OP_J);
    assign branch_target = if_id_pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign jump_target   = {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00};

    assign redirect_valid = branch_taken || jump_taken;
    assign if_id_flush    = redirect_valid;
    assign redirect_pc    = (opcode == OP_J) ? jump_target : branch_target;

    // Priority: hold keeps everything, stall inserts a bubble (only valid and
    // ctrl matter for a bubble, so the data fields are left as they were).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_valid    <= 1'b0;
            id_ex_ctrl     <= '0;
            id_ex_rd_data1 <= '0;
            id_ex_rd_data2 <= '0;
            id_ex_imm      <= '0;
            id_ex_rs       <= '0;
            id_ex_rt       <= '0;
            id_ex_rd       <= '0;
        end else if (!ex_hold) begin
            if (stall_en) begin
                id_ex_valid <= 1'b0;
                id_ex_ctrl  <= '0;
            end else begin
                id_ex_valid    <= if_id_valid;
                id_ex_ctrl     <= ctrl;
                id_ex_rd_data1 <= rd_data1;
                id_ex_rd_data2 <= rd_data2;
                id_ex_imm      <= imm_ext;
                id_ex_rs       <= id_rs;
                id_ex_rt       <= id_rt;
                id_ex_rd       <= rd_field;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (stall_en && !ex_hold && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_stage_v2.sv
// Directed bench for decode_stage_v2. A second instance with CNT_W=2 shares
// all stimulus so the bubble counter saturation can be observed.
module tb_decode_stage_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc_plus4;
    logic        stall_en, ex_hold;
    logic        wb_reg_write;
    logic [4:0]  wb_wr_addr;
    logic [31:0] wb_wr_data;

    logic [4:0]  id_rs, id_rt, id_ex_rs, id_ex_rt, id_ex_rd;
    logic        redirect_valid, if_id_flush, id_ex_valid;
    logic [31:0] redirect_pc, id_ex_rd_data1, id_ex_rd_data2, id_ex_imm;
    logic [7:0]  id_ex_ctrl;
    logic [15:0] bubble_cnt;

    logic [4:0]  s_rs, s_rt, s_ex_rs, s_ex_rt, s_ex_rd;
    logic        s_redirect_valid, s_flush, s_ex_valid;
    logic [31:0] s_redirect_pc, s_ex_rd_data1, s_ex_rd_data2, s_ex_imm;
    logic [7:0]  s_ex_ctrl;
    logic [1:0]  s_bubble_cnt;

    int n_vec  = 0;
    int n_err  = 0;

    localparam logic [7:0] CTRL_R    = 8'hA1;
    localparam logic [7:0] CTRL_ADDI = 8'h41;

    always #5 clk = ~clk;

    decode_stage_v2 dut (
        .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4), .stall_en(stall_en), .ex_hold(ex_hold),
        .wb_reg_write(wb_reg_write), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
        .id_rs(id_rs), .id_rt(id_rt), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_id_flush(if_id_flush), .id_ex_valid(id_ex_valid),
        .id_ex_ctrl(id_ex_ctrl), .id_ex_rd_data1(id_ex_rd_data1),
        .id_ex_rd_data2(id_ex_rd_data2), .id_ex_imm(id_ex_imm), .id_ex_rs(id_ex_rs),
        .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd), .bubble_cnt(bubble_cnt)
    );

    decode_stage_v2 #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4), .stall_en(stall_en), .ex_hold(ex_hold),
        .wb_reg_write(wb_reg_write), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
        .id_rs(s_rs), .id_rt(s_rt), .redirect_valid(s_redirect_valid),
        .redirect_pc(s_redirect_pc), .if_id_flush(s_flush), .id_ex_valid(s_ex_valid),
        .id_ex_ctrl(s_ex_ctrl), .id_ex_rd_data1(s_ex_rd_data1),
        .id_ex_rd_data2(s_ex_rd_data2), .id_ex_imm(s_ex_imm), .id_ex_rs(s_ex_rs),
        .id_ex_rt(s_ex_rt), .id_ex_rd(s_ex_rd), .bubble_cnt(s_bubble_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {6'h02, target};
    endfunction

    task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
        wb_reg_write = en;
        wb_wr_addr   = addr;
        wb_wr_data   = data;
    endtask

    task automatic present(input logic v, input logic [31:0] instr, input logic [31:0] pc4);
        if_id_valid    = v;
        if_id_instr    = instr;
        if_id_pc_plus4 = pc4;
    endtask

    initial begin
        rst = 1'b0;
        stall_en = 1'b0;
        ex_hold  = 1'b0;
        present(1'b0, 32'h0, 32'h0);
        wb(1'b0, 5'd0, 32'h0);

        // Reset for 3 cycles, then release.
        repeat (3) step();
        check("rst_valid", id_ex_valid, 0);
        check("rst_ctrl",  id_ex_ctrl, 0);
        check("rst_bcnt",  bubble_cnt, 0);
        rst = 1'b1;
        #1;
        check("rel_redirect", redirect_valid, 0);
        check("rel_data1",    id_ex_rd_data1, 0);

        // r3 = 5, r4 = 5.
        wb(1'b1, 5'd3, 32'd5); step();
        wb(1'b1, 5'd4, 32'd5); step();
        wb(1'b0, 5'd0, 32'h0);

        // beq r3,r4,+4 at pc_plus4 0x100: taken to 0x110.
        present(1'b1, enc_i(6'h04, 5'd3, 5'd4, 16'd4), 32'h100);
        #1;
        check("beq_rs",       id_rs, 3);
        check("beq_rt",       id_rt, 4);
        check("beq_redirect", redirect_valid, 1);
        check("beq_pc",       redirect_pc, 32'h110);
        check("beq_flush",    if_id_flush, 1);
        step();
        check("beq_ex_valid", id_ex_valid, 1);
        check("beq_ex_ctrl",  id_ex_ctrl, 0);
        check("beq_ex_imm",   id_ex_imm, 32'h4);

        // bne on equal operands: not taken.
        present(1'b1, enc_i(6'h05, 5'd3, 5'd4, 16'd4), 32'h100);
        #1;
        check("bne_redirect", redirect_valid, 0);
        check("bne_flush",    if_id_flush, 0);
        step();

        // beq compares after bypass: r4 becomes 6 this cycle -> not taken.
        present(1'b1, enc_i(6'h04, 5'd3, 5'd4, 16'd4), 32'h100);
        wb(1'b1, 5'd4, 32'd6);
        #1;
        check("beq_byp_redirect", redirect_valid, 0);
        step();

        // addi r8,r7,1 while WB writes r7=0xA5.
        present(1'b1, enc_i(6'h08, 5'd7, 5'd8, 16'd1), 32'h104);
        wb(1'b1, 5'd7, 32'hA5);
        step();
        wb(1'b0, 5'd0, 32'h0);
        check("addi_byp_data1", id_ex_rd_data1, 32'hA5);
        check("addi_ctrl",      id_ex_ctrl, CTRL_ADDI);
        check("addi_rt",        id_ex_rt, 8);
        check("addi_imm",       id_ex_imm, 32'h1);

        // Write to r0 is ignored, including the bypass.
        present(1'b1, enc_i(6'h08, 5'd0, 5'd9, 16'd2), 32'h108);
        wb(1'b1, 5'd0, 32'hFF);
        step();
        wb(1'b0, 5'd0, 32'h0);
        check("r0_data1", id_ex_rd_data1, 0);

        // Backward branch: beq r0,r0,-1 at 0x100 -> 0xFC.
        present(1'b1, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF), 32'h100);
        #1;
        check("bneg_redirect", redirect_valid, 1);
        check("bneg_pc",       redirect_pc, 32'hFC);
        step();
        check("bneg_imm_sext", id_ex_imm, 32'hFFFF_FFFF);

        // Two stall cycles with a jump in IF/ID: bubbles, redirect suppressed.
        present(1'b1, enc_j(26'h40), 32'h200);
        stall_en = 1'b1;
        #1;
        check("stall_redirect", redirect_valid, 0);
        step();
        check("bub1_valid", id_ex_valid, 0);
        check("bub1_ctrl",  id_ex_ctrl, 0);
        check("bub1_cnt",   bubble_cnt, 1);
        step();
        check("bub2_valid", id_ex_valid, 0);
        check("bub2_cnt",   bubble_cnt, 2);
        check("bub2_cnt_s", s_bubble_cnt, 2);

        // add r10,r3,r4 loads normally (r3=5, r4=6).
        stall_en = 1'b0;
        present(1'b1, enc_r(5'd3, 5'd4, 5'd10), 32'h204);
        step();
        check("add_ctrl",  id_ex_ctrl, CTRL_R);
        check("add_rd",    id_ex_rd, 10);
        check("add_data1", id_ex_rd_data1, 5);
        check("add_data2", id_ex_rd_data2, 6);

        // Hold alone suppresses a jump redirect.
        ex_hold = 1'b1;
        present(1'b1, enc_j(26'h40), 32'h208);
        #1;
        check("hold_redirect", redirect_valid, 0);

        // Hold plus stall for 2 cycles: ID/EX and counter frozen.
        stall_en = 1'b1;
        present(1'b1, enc_i(6'h2B, 5'd1, 5'd2, 16'd8), 32'h208);
        step();
        step();
        check("hold_valid", id_ex_valid, 1);
        check("hold_ctrl",  id_ex_ctrl, CTRL_R);
        check("hold_rd",    id_ex_rd, 10);
        check("hold_data2", id_ex_rd_data2, 6);
        check("hold_cnt",   bubble_cnt, 2);

        // Five more stalls: 7 in the wide counter, saturated at 3 in CNT_W=2.
        ex_hold = 1'b0;
        repeat (5) step();
        check("cnt_wide", bubble_cnt, 7);
        check("cnt_sat",  s_bubble_cnt, 3);

        // j 0x40 at pc_plus4 0x30000004 -> 0x30000100.
        stall_en = 1'b0;
        present(1'b1, enc_j(26'h40), 32'h3000_0004);
        #1;
        check("j_redirect", redirect_valid, 1);
        check("j_pc",       redirect_pc, 32'h3000_0100);
        check("j_flush",    if_id_flush, 1);
        step();
        check("j_ex_valid", id_ex_valid, 1);
        check("j_ex_ctrl",  id_ex_ctrl, 0);

        // Unknown opcode decodes to zero control but stays valid.
        present(1'b1, enc_i(6'h3F, 5'd3, 5'd4, 16'd0), 32'h300);
        step();
        check("unk_valid", id_ex_valid, 1);
        check("unk_ctrl",  id_ex_ctrl, 0);

        // Invalid slot: no redirect, ID/EX loads as invalid.
        present(1'b0, enc_j(26'h40), 32'h304);
        #1;
        check("inv_redirect", redirect_valid, 0);
        step();
        check("inv_valid", id_ex_valid, 0);

        // Reset asserted mid-stall clears everything asynchronously.
        present(1'b1, enc_i(6'h08, 5'd3, 5'd9, 16'd7), 32'h400);
        stall_en = 1'b1;
        step();
        check("pre_rst_cnt", bubble_cnt, 8);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_cnt",   bubble_cnt, 0);
        check("mid_rst_cnt_s", s_bubble_cnt, 0);
        check("mid_rst_rd",    id_ex_rd, 0);
        step();
        rst = 1'b1;
        stall_en = 1'b0;
        step();
        check("post_rst_valid", id_ex_valid, 1);
        check("post_rst_ctrl",  id_ex_ctrl, CTRL_ADDI);
        check("post_rst_data1", id_ex_rd_data1, 0);
        check("post_rst_imm",   id_ex_imm, 32'h7);
        check("post_rst_cnt",   bubble_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
